reg_select_scoreboard: RTL and testbench



---
 rtl/mini_src_pkg.sv | 9 +
 rtl/onehot_dec.sv | 11 +
 rtl/reg_select_scoreboard.sv | 70 +++++++
 tb/tb_reg_select_scoreboard.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mini_src_pkg.sv
// mini_src_pkg: shared Mini SRC datapath defaults for control unit, register file and select logic
package mini_src_pkg;
  localparam int P_DATA_W  = 32;
  localparam int P_NREGS   = 16;
  localparam int P_RA_LSB  = 23;
  localparam int P_RB_LSB  = 19;
  localparam int P_RC_LSB  = 15;
  localparam int P_CONST_W = 19;
endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: index plus enable to one-hot register enable vector
module onehot_dec #(
  parameter int NREGS = 16,
  parameter int IDXW  = $clog2(NREGS)
) (
  input  logic [IDXW-1:0]  i_idx,
  input  logic             i_en,
  output logic [NREGS-1:0] o_onehot
);
  assign o_onehot = NREGS'(i_en) << i_idx;
endmodule

// File: rtl/reg_select_scoreboard.sv
// reg_select_scoreboard: Ra/Rb/Rc decode to one-hot enables, constant sign-extension, pending-write scoreboard
module reg_select_scoreboard
  import mini_src_pkg::*;
#(
  parameter int DATA_W  = P_DATA_W,
  parameter int NREGS   = P_NREGS,
  parameter int IDXW    = $clog2(NREGS),
  parameter int RA_LSB  = P_RA_LSB,
  parameter int RB_LSB  = P_RB_LSB,
  parameter int RC_LSB  = P_RC_LSB,
  parameter int CONST_W = P_CONST_W
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] IR,
  input  logic              ir_load,
  input  logic              Gra,
  input  logic              Grb,
  input  logic              Grc,
  input  logic              e_Rin,
  input  logic              e_Rout,
  input  logic              BAout,
  input  logic              reserve,
  input  logic              commit,
  input  logic [IDXW-1:0]   commit_idx,
  output logic [NREGS-1:0]  Rin,
  output logic [NREGS-1:0]  Rout,
  output logic [IDXW-1:0]   sel_idx,
  output logic [DATA_W-1:0] C_sign_ext,
  output logic [NREGS-1:0]  pending,
  output logic [IDXW:0]     pend_cnt,
  output logic              src_busy
);
  logic [DATA_W-1:0] r_ir;
  logic [NREGS-1:0]  r_pend;
  logic [IDXW:0]     r_cnt;
  logic [IDXW-1:0]   w_ra, w_rb, w_rc, w_sel;
  logic              w_rout_en, w_inc, w_dec, w_unused;
  assign w_ra      = r_ir[RA_LSB +: IDXW];
  assign w_rb      = r_ir[RB_LSB +: IDXW];
  assign w_rc      = r_ir[RC_LSB +: IDXW];
  assign w_sel     = Gra ? w_ra : Grb ? w_rb : Grc ? w_rc : '0;
  assign w_rout_en = e_Rout & ~(BAout & (w_sel == '0)) & ~clear;
  assign w_unused  = ^r_ir;
  onehot_dec #(.NREGS(NREGS), .IDXW(IDXW)) u_rin (
    .i_idx(w_sel), .i_en(e_Rin & ~clear), .o_onehot(Rin)
  );
  onehot_dec #(.NREGS(NREGS), .IDXW(IDXW)) u_rout (
    .i_idx(w_sel), .i_en(w_rout_en), .o_onehot(Rout)
  );
  assign sel_idx    = w_sel;
  assign src_busy   = w_rout_en & r_pend[w_sel];
  assign C_sign_ext = {{(DATA_W-CONST_W){r_ir[CONST_W-1]}}, r_ir[CONST_W-1:0]};
  assign pending    = r_pend;
  assign pend_cnt   = r_cnt;
  // a commit hitting the index being reserved is overridden by the reserve, so it must not decrement
  assign w_inc = reserve & ~r_pend[w_ra];
  assign w_dec = commit & r_pend[commit_idx] & ~(reserve & (w_ra == commit_idx));
  always_ff @(posedge clock) begin
    if (clear) begin
      r_ir   <= '0;
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      if (ir_load) r_ir <= IR;
      r_pend <= (r_pend & ~(NREGS'(commit) << commit_idx)) | (NREGS'(reserve) << w_ra);
      r_cnt  <= r_cnt + (IDXW+1)'(w_inc) - (IDXW+1)'(w_dec);
    end
  end
endmodule

// File: tb/tb_reg_select_scoreboard.sv
// tb_reg_select_scoreboard: directed vector table plus randomized run against a behavioural model
module tb_reg_select_scoreboard;
  logic        clock = 0, clear = 1;
  logic [31:0] IR = 0;
  logic        ir_load = 0, Gra = 0, Grb = 0, Grc = 0, e_Rin = 0, e_Rout = 0, BAout = 0;
  logic        reserve = 0, commit = 0;
  logic [3:0]  commit_idx = 0;
  logic [15:0] Rin, Rout, pending;
  logic [3:0]  sel_idx;
  logic [31:0] C_sign_ext;
  logic [4:0]  pend_cnt;
  logic        src_busy;
  int n_chk = 0, n_fail = 0;
  bit [31:0] m_ir = 0;
  bit        m_pend [16];
  always #5 clock = ~clock;
  reg_select_scoreboard dut (
    .clock(clock), .clear(clear), .IR(IR), .ir_load(ir_load), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .e_Rin(e_Rin), .e_Rout(e_Rout), .BAout(BAout), .reserve(reserve), .commit(commit),
    .commit_idx(commit_idx), .Rin(Rin), .Rout(Rout), .sel_idx(sel_idx), .C_sign_ext(C_sign_ext),
    .pending(pending), .pend_cnt(pend_cnt), .src_busy(src_busy)
  );
  typedef struct {
    logic [31:0] ir;
    logic ld, gra, grb, grc, erin, erout, ba, res, com;
    logic [3:0] cidx;
    logic clr;
    logic [15:0] rin, rout;
    logic [3:0] sel;
    logic busy;
    logic [15:0] pend;
    logic [4:0] cnt;
    logic [31:0] c;
  } vec_t;
  vec_t tbl [24];
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic drive(input vec_t v);
    IR = v.ir; ir_load = v.ld; Gra = v.gra; Grb = v.grb; Grc = v.grc;
    e_Rin = v.erin; e_Rout = v.erout; BAout = v.ba;
    reserve = v.res; commit = v.com; commit_idx = v.cidx; clear = v.clr;
  endtask
  function automatic int field(input bit [31:0] ir, input int lsb);
    return (ir >> lsb) % 16;
  endfunction
  task automatic model_check();
    int sel, cnt;
    bit zero;
    bit [15:0] pv, rin_e, rout_e;
    sel = Gra ? field(m_ir, 23) : Grb ? field(m_ir, 19) : Grc ? field(m_ir, 15) : 0;
    zero = BAout && sel == 0;
    cnt = 0;
    pv = 0;
    for (int i = 0; i < 16; i++) begin
      cnt += m_pend[i];
      if (m_pend[i]) pv += 16'(2 ** i);
    end
    rin_e = (e_Rin && !clear) ? 16'(2 ** sel) : 16'h0;
    rout_e = (e_Rout && !zero && !clear) ? 16'(2 ** sel) : 16'h0;
    check("m_sel", 32'(sel_idx), 32'(sel));
    check("m_rin", 32'(Rin), 32'(rin_e));
    check("m_rout", 32'(Rout), 32'(rout_e));
    check("m_busy", 32'(src_busy), 32'(e_Rout && !zero && !clear && m_pend[sel]));
    check("m_pend", 32'(pending), 32'(pv));
    check("m_cnt", 32'(pend_cnt), 32'(cnt));
    check("m_const", C_sign_ext, (m_ir % 32'h40000) - ((m_ir / 32'h40000) % 2) * 32'h40000);
  endtask
  task automatic edge_update();
    int ra;
    @(posedge clock);
    ra = field(m_ir, 23);
    if (clear) begin
      m_ir = 0;
      for (int i = 0; i < 16; i++) m_pend[i] = 0;
    end else begin
      if (commit) m_pend[commit_idx] = 0;
      if (reserve) m_pend[ra] = 1;
      if (ir_load) m_ir = IR;
    end
    #1;
  endtask
  initial begin
    tbl[0]  = '{0,0,1,0,0,1,1,0,1,0,0,1, 0,0,0,0,0,0,0};
    tbl[1]  = '{32'h0A3B8000,1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0};
    tbl[2]  = '{0,0,1,0,0,1,0,0,0,0,0,0, 16'h10,0,4,0,0,0,32'h00038000};
    tbl[3]  = '{0,0,0,1,0,0,1,0,0,0,0,0, 0,16'h80,7,0,0,0,32'h00038000};
    tbl[4]  = '{0,0,0,0,1,1,1,0,0,0,0,0, 16'h80,16'h80,7,0,0,0,32'h00038000};
    tbl[5]  = '{0,0,0,0,0,1,0,0,0,0,0,0, 16'h1,0,0,0,0,0,32'h00038000};
    tbl[6]  = '{32'h02AC0001,1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,32'h00038000};
    tbl[7]  = '{0,0,0,1,0,0,1,0,1,0,0,0, 0,16'h20,5,0,0,0,32'hFFFC0001};
    tbl[8]  = '{0,0,0,1,0,0,1,0,0,1,5,0, 0,16'h20,5,1,16'h20,1,32'hFFFC0001};
    tbl[9]  = '{0,0,0,1,0,0,1,0,0,0,0,0, 0,16'h20,5,0,0,0,32'hFFFC0001};
    tbl[10] = '{32'h0003FFFF,1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,32'hFFFC0001};
    tbl[11] = '{0,0,0,0,0,0,0,0,1,0,0,0, 0,0,0,0,0,0,32'h0003FFFF};
    tbl[12] = '{0,0,1,0,0,0,1,1,0,0,0,0, 0,0,0,0,16'h1,1,32'h0003FFFF};
    tbl[13] = '{0,0,1,0,0,0,1,0,0,0,0,0, 0,16'h1,0,1,16'h1,1,32'h0003FFFF};
    tbl[14] = '{32'h01800000,1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,16'h1,1,32'h0003FFFF};
    tbl[15] = '{0,0,0,0,0,0,0,0,1,1,3,0, 0,0,0,0,16'h1,1,0};
    tbl[16] = '{0,0,0,0,0,0,0,0,0,1,9,0, 0,0,0,0,16'h9,2,0};
    tbl[17] = '{0,0,1,0,0,1,1,0,0,0,0,0, 16'h8,16'h8,3,1,16'h9,2,0};
    tbl[18] = '{32'h00800000,1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,16'h9,2,0};
    tbl[19] = '{32'h01000000,1,0,0,0,0,0,0,1,0,0,0, 0,0,0,0,16'h9,2,0};
    tbl[20] = '{32'h03000000,1,0,0,0,0,0,0,1,0,0,0, 0,0,0,0,16'h0B,3,0};
    tbl[21] = '{0,0,0,0,0,0,0,0,1,0,0,0, 0,0,0,0,16'h0F,4,0};
    tbl[22] = '{0,0,1,0,0,1,1,0,1,1,0,1, 0,0,6,0,16'h4F,5,0};
    tbl[23] = '{0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0};
    for (int i = 0; i < 16; i++) m_pend[i] = 0;
    clear = 1;
    repeat (2) edge_update();
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i]);
      #1;
      check($sformatf("v%0d_rin", i), 32'(Rin), 32'(tbl[i].rin));
      check($sformatf("v%0d_rout", i), 32'(Rout), 32'(tbl[i].rout));
      check($sformatf("v%0d_sel", i), 32'(sel_idx), 32'(tbl[i].sel));
      check($sformatf("v%0d_busy", i), 32'(src_busy), 32'(tbl[i].busy));
      check($sformatf("v%0d_pend", i), 32'(pending), 32'(tbl[i].pend));
      check($sformatf("v%0d_cnt", i), 32'(pend_cnt), 32'(tbl[i].cnt));
      check($sformatf("v%0d_const", i), C_sign_ext, tbl[i].c);
      edge_update();
    end
    for (int n = 0; n < 600; n++) begin
      IR = $urandom;
      ir_load = $urandom_range(0, 3) == 0;
      Gra = $urandom_range(0, 1) == 1;
      Grb = $urandom_range(0, 1) == 1;
      Grc = $urandom_range(0, 1) == 1;
      e_Rin = $urandom_range(0, 1) == 1;
      e_Rout = $urandom_range(0, 1) == 1;
      BAout = $urandom_range(0, 2) == 0;
      reserve = $urandom_range(0, 1) == 1;
      commit = $urandom_range(0, 2) == 0;
      commit_idx = 4'($urandom_range(0, 15));
      clear = $urandom_range(0, 59) == 0;
      #1;
      model_check();
      edge_update();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
